// File: rtl/exec_stall_ctrl.sv
// Execute-stage multi-cycle sequencer: FPU/divide latency, UART IN/OUT ring-buffer waits.
// Optional EXEC_STALL_TIMEOUT_EN adds a bounded UART wait and sticky io_timeout flag.
module exec_stall_ctrl #(
   parameter int FPU_LAT = 2,
   parameter int DIV_LAT = 8,
   parameter int CNT_W   = 32
`ifdef EXEC_STALL_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 1_000_000
`endif
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             issue,
   input  logic [2:0]       op_class,
   input  logic             flush,
   input  logic             rx_empty,
   input  logic             tx_full,
   output logic             stall,
   output logic             fu_start,
   output logic             capture,
   output logic             rx_pop,
   output logic             tx_push,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             busy
`ifdef EXEC_STALL_TIMEOUT_EN
   ,
   output logic             io_timeout
`endif
);

   localparam int MAX_LAT = (FPU_LAT > DIV_LAT) ? FPU_LAT : DIV_LAT;
   localparam int LW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_LAT = 2'd1,
      WAIT_RX  = 2'd2,
      WAIT_TX  = 2'd3
   } state_t;

   state_t         state, state_nxt;
   logic [LW-1:0]  cnt, cnt_nxt;

`ifdef EXEC_STALL_TIMEOUT_EN
   logic [31:0]    wait_cnt, wait_nxt;
   logic           tmo_set;
   logic           wait_expired;
   assign wait_expired = (wait_cnt == 32'(TIMEOUT));
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = 1'b0;
      fu_start  = 1'b0;
      capture   = 1'b0;
      rx_pop    = 1'b0;
      tx_push   = 1'b0;
`ifdef EXEC_STALL_TIMEOUT_EN
      wait_nxt  = wait_cnt;
      tmo_set   = 1'b0;
`endif
      // Strobes are suppressed under reset so an abandoned op never commits.
      if (!rstn) begin
         state_nxt = IDLE;
      end else if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
`ifdef EXEC_STALL_TIMEOUT_EN
               wait_nxt = '0;
`endif
               if (issue) begin
                  case (op_class)
                     3'd1: begin
                        stall     = 1'b1;
                        fu_start  = 1'b1;
                        cnt_nxt   = LW'(FPU_LAT - 1);
                        state_nxt = WAIT_LAT;
                     end
                     3'd2: begin
                        stall     = 1'b1;
                        fu_start  = 1'b1;
                        cnt_nxt   = LW'(DIV_LAT - 1);
                        state_nxt = WAIT_LAT;
                     end
                     3'd3: begin
                        stall     = 1'b1;
                        state_nxt = WAIT_RX;
                     end
                     3'd4: begin
                        stall     = 1'b1;
                        state_nxt = WAIT_TX;
                     end
                     default: ;
                  endcase
               end
            end
            WAIT_LAT: begin
               if (cnt != '0) begin
                  stall   = 1'b1;
                  cnt_nxt = cnt - LW'(1);
               end else begin
                  capture   = 1'b1;
                  state_nxt = IDLE;
               end
            end
            WAIT_RX: begin
               if (!rx_empty) begin
                  rx_pop    = 1'b1;
                  capture   = 1'b1;
                  state_nxt = IDLE;
`ifdef EXEC_STALL_TIMEOUT_EN
               end else if (wait_expired) begin
                  // Datapath writes back zero: no pop, so the head is not selected.
                  capture   = 1'b1;
                  tmo_set   = 1'b1;
                  state_nxt = IDLE;
`endif
               end else begin
                  stall = 1'b1;
`ifdef EXEC_STALL_TIMEOUT_EN
                  wait_nxt = wait_cnt + 32'd1;
`endif
               end
            end
            WAIT_TX: begin
               if (!tx_full) begin
                  tx_push   = 1'b1;
                  state_nxt = IDLE;
`ifdef EXEC_STALL_TIMEOUT_EN
               end else if (wait_expired) begin
                  tmo_set   = 1'b1;
                  state_nxt = IDLE;
`endif
               end else begin
                  stall = 1'b1;
`ifdef EXEC_STALL_TIMEOUT_EN
                  wait_nxt = wait_cnt + 32'd1;
`endif
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

`ifdef EXEC_STALL_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wait_cnt   <= '0;
         io_timeout <= 1'b0;
      end else begin
         wait_cnt <= wait_nxt;
         if (tmo_set)
            io_timeout <= 1'b1;
      end
   end
`endif

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_exec_stall_ctrl.sv
// Directed plus randomized bench for exec_stall_ctrl against a deadline-based op model.
module tb_exec_stall_ctrl;
   localparam int FPU_LAT = 2;
   localparam int DIV_LAT = 8;
   localparam int CNT_W   = 4;
   localparam int SAT     = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rstn, issue, flush, rx_empty, tx_full;
   logic [2:0]       op_class;
   logic             stall, fu_start, capture, rx_pop, tx_push, busy;
   logic [CNT_W-1:0] stall_cnt;

   exec_stall_ctrl #(.FPU_LAT(FPU_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .issue(issue), .op_class(op_class), .flush(flush),
      .rx_empty(rx_empty), .tx_full(tx_full), .stall(stall), .fu_start(fu_start),
      .capture(capture), .rx_pop(rx_pop), .tx_push(tx_push), .stall_cnt(stall_cnt),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: kind of outstanding op (0 none, 1 fixed latency, 2 IN, 3 OUT),
   // the absolute cycle a latency op delivers, and the stall total.
   int pend = 0;
   int done_at = 0;
   int cyc = 0;
   int sc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input logic r, input logic i, input logic [2:0] c,
                       input logic f, input logic rxe, input logic txf);
      logic e_stall, e_fu, e_cap, e_pop, e_push;
      int np, nd;
      @(negedge clk);
      rstn = r; issue = i; op_class = c; flush = f; rx_empty = rxe; tx_full = txf;
      #1;
      e_stall = 0; e_fu = 0; e_cap = 0; e_pop = 0; e_push = 0;
      np = pend; nd = done_at;
      if (!r) np = 0;
      else if (f) np = 0;
      else begin
         case (pend)
            0: if (i) begin
               if (c == 3'd1 || c == 3'd2) begin
                  e_stall = 1; e_fu = 1; np = 1;
                  nd = cyc + ((c == 3'd1) ? FPU_LAT : DIV_LAT);
               end else if (c == 3'd3) begin
                  e_stall = 1; np = 2;
               end else if (c == 3'd4) begin
                  e_stall = 1; np = 3;
               end
            end
            1: if (cyc == done_at) begin e_cap = 1; np = 0; end else e_stall = 1;
            2: if (!rxe) begin e_cap = 1; e_pop = 1; np = 0; end else e_stall = 1;
            3: if (!txf) begin e_push = 1; np = 0; end else e_stall = 1;
            default: ;
         endcase
      end
      chk("busy", 32'(busy), 32'(pend != 0));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("fu_start", 32'(fu_start), 32'(e_fu));
      chk("capture", 32'(capture), 32'(e_cap));
      chk("rx_pop", 32'(rx_pop), 32'(e_pop));
      chk("tx_push", 32'(tx_push), 32'(e_push));
      chk("stall_cnt", 32'(stall_cnt), 32'(sc));
      @(posedge clk);
      if (!r) sc = 0;
      else if (e_stall && sc < SAT) sc = sc + 1;
      pend = np; done_at = nd; cyc++;
   endtask

   task automatic do_reset();
      step(0, 0, 3'd0, 0, 1, 1);
      step(0, 0, 3'd0, 0, 1, 1);
   endtask

   initial begin
      rstn = 0; issue = 0; op_class = 0; flush = 0; rx_empty = 1; tx_full = 1;
      @(posedge clk);
      @(posedge clk);
      do_reset();

      // Single-cycle class for 10 cycles: nothing asserted
      for (int k = 0; k < 10; k++) step(1, 1, 3'd0, 0, 1, 1);
      chk("class0_cnt", 32'(stall_cnt), 32'd0);
      step(1, 1, 3'd6, 0, 1, 1);

      // FPU: stall T..T+1, capture T+2, idle T+3
      step(1, 1, 3'd1, 0, 1, 1);
      step(1, 1, 3'd1, 0, 1, 1);
      step(1, 1, 3'd1, 0, 1, 1);
      chk("fpu_capture", 32'(capture), 32'd1);
      step(1, 0, 3'd0, 0, 1, 1);
      chk("fpu_busy_after", 32'(busy), 32'd0);

      // Divide from a clean counter: exactly 8 stall cycles
      do_reset();
      for (int k = 0; k < DIV_LAT + 1; k++) step(1, 1, 3'd2, 0, 1, 1);
      step(1, 0, 3'd0, 0, 1, 1);
      chk("div_stall_cnt", 32'(stall_cnt), 32'd8);

      // IN with buffer empty 5 cycles after issue, then data arrives
      do_reset();
      for (int k = 0; k < 6; k++) step(1, 1, 3'd3, 0, 1, 1);
      step(1, 1, 3'd3, 0, 0, 1);
      step(1, 0, 3'd0, 0, 0, 1);
      chk("in_stall_cnt", 32'(stall_cnt), 32'd6);
      // IN with data already present: 1 stall cycle, pop next
      step(1, 1, 3'd3, 0, 0, 1);
      step(1, 1, 3'd3, 0, 0, 1);
      step(1, 0, 3'd0, 0, 0, 1);

      // OUT with tx_full for 3 cycles
      step(1, 1, 3'd4, 0, 1, 1);
      step(1, 1, 3'd4, 0, 1, 1);
      step(1, 1, 3'd4, 0, 1, 1);
      step(1, 1, 3'd4, 0, 1, 0);
      step(1, 0, 3'd0, 0, 1, 0);

      // Flush in WAIT_LAT cycle 3 of a divide
      step(1, 1, 3'd2, 0, 1, 1);
      step(1, 1, 3'd2, 0, 1, 1);
      step(1, 1, 3'd2, 0, 1, 1);
      step(1, 1, 3'd2, 1, 1, 1);
      step(1, 0, 3'd0, 0, 1, 1);
      chk("flush_busy", 32'(busy), 32'd0);
      // Flush alongside an issue in IDLE blocks it
      step(1, 1, 3'd1, 1, 1, 1);
      step(1, 0, 3'd0, 0, 1, 1);

      // Reset during WAIT_RX with data present: no pop
      step(1, 1, 3'd3, 0, 1, 1);
      step(1, 1, 3'd3, 0, 1, 1);
      step(0, 1, 3'd3, 0, 0, 1);
      step(1, 0, 3'd0, 0, 0, 1);
      chk("rst_busy", 32'(busy), 32'd0);

      // Long stall to reach counter saturation
      step(1, 1, 3'd4, 0, 1, 1);
      for (int k = 0; k < SAT + 4; k++) step(1, 1, 3'd4, 0, 1, 1);
      chk("sat_cnt", 32'(stall_cnt), 32'(SAT));
      step(1, 1, 3'd4, 0, 1, 0);

      // Randomized traffic
      for (int k = 0; k < 800; k++) begin
         step($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0,
              3'($urandom_range(0, 7)), $urandom_range(0, 24) == 0,
              $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
